// File: rtl/mdu_pkg.sv
// Shared types and sizing for the iterative multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } mdop_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } mdu_state_t;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH) + 1;

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               isDiv,
    output logic [2*WIDTH-1:0] accNext
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Multiply: acc = {partial, multiplier}; the carry out of the add shifts into the top.
    // Divide:   acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
    always_comb begin
        addend  = acc[0] ? operand : '0;
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        shifted = acc[2*WIDTH-1:WIDTH-1];
        diff    = shifted[WIDTH-1:0] - operand;
        if (isDiv) begin
            if (shifted >= {1'b0, operand}) begin
                accNext = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            accNext = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mdop,
    input  logic [WIDTH-1:0] portA,
    input  logic [WIDTH-1:0] portB,
    input  logic             hiWe,
    input  logic             loWe,
    input  logic [WIDTH-1:0] wrData,
    output logic             busy,
    output logic             done,
    output logic             divZeroF,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_t         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] accNext;
    logic [WIDTH-1:0]   opnd;
    logic               isDiv;
    logic               negRes;
    logic               negRem;

    mdop_t              op;
    logic               signedOp;
    logic               reqDiv;
    logic               aNeg;
    logic               bNeg;
    logic [WIDTH-1:0]   aMag;
    logic [WIDTH-1:0]   bMag;
    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix;
    logic [WIDTH-1:0]   remFix;

    always_comb begin
        op       = mdop_t'(mdop);
        signedOp = (op == MULT) || (op == DIV);
        reqDiv   = (op == DIV) || (op == DIVU);
        aNeg     = signedOp & portA[WIDTH-1];
        bNeg     = signedOp & portB[WIDTH-1];
        aMag     = aNeg ? ('0 - portA) : portA;
        bMag     = bNeg ? ('0 - portB) : portB;
        prodFix  = negRes ? ('0 - acc) : acc;
        quoFix   = negRes ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        remFix   = negRem ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    mdu_step #(.WIDTH(WIDTH)) uStep (
        .acc    (acc),
        .operand(opnd),
        .isDiv  (isDiv),
        .accNext(accNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            isDiv    <= 1'b0;
            negRes   <= 1'b0;
            negRem   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            divZeroF <= 1'b0;
            hiOut    <= '0;
            loOut    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hiWe) hiOut <= wrData;
                    if (loWe) loOut <= wrData;
                    if (start) begin
                        cnt      <= '0;
                        busy     <= 1'b1;
                        isDiv    <= reqDiv;
                        negRem   <= aNeg;
                        negRes   <= aNeg ^ bNeg;
                        opnd     <= reqDiv ? bMag : aMag;
                        acc      <= {{WIDTH{1'b0}}, (reqDiv ? aMag : bMag)};
                        if (reqDiv && (portB == '0)) begin
                            divZeroF <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            divZeroF <= 1'b0;
                            state    <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= accNext;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= FINISH;
                end
                FINISH: begin
                    if (!divZeroF) begin
                        if (isDiv) begin
                            hiOut <= remFix;
                            loOut <= quoFix;
                        end else begin
                            {hiOut, loOut} <= prodFix;
                        end
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO/flag queued at issue, checked on done.
module tb_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mdop = 2'd0;
    logic [31:0] portA = '0;
    logic [31:0] portB = '0;
    logic        hiWe = 1'b0;
    logic        loWe = 1'b0;
    logic [31:0] wrData = '0;
    logic        busy;
    logic        done;
    logic        divZeroF;
    logic [31:0] hiOut;
    logic [31:0] loOut;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sbQ[$];
    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [31:0] mHi = '0;
    logic [31:0] mLo = '0;

    always #5 clk = ~clk;

    mdu #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .mdop    (mdop),
        .portA   (portA),
        .portB   (portB),
        .hiWe    (hiWe),
        .loWe    (loWe),
        .wrData  (wrData),
        .busy    (busy),
        .done    (done),
        .divZeroF(divZeroF),
        .hiOut   (hiOut),
        .loOut   (loOut)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [31:0] curHi,
                                   input logic [31:0] curLo);
        exp_t            e;
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        e.dz = 1'b0;
        case (op)
            2'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'd1: begin p = ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1; e.hi = curHi; e.lo = curLo;
                end else if (op == 2'd2) begin
                    p = sa / sb; e.lo = p[31:0];
                    p = sa % sb; e.hi = p[31:0];
                end else begin
                    p = ua / ub; e.lo = p[31:0];
                    p = ua % ub; e.hi = p[31:0];
                end
            end
        endcase
        return e;
    endfunction

    // Result monitor: every done pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (done) begin
            if (sbQ.size() == 0) begin
                checkVal("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkVal("hi", 64'(hiOut), 64'(e.hi));
                checkVal("lo", 64'(loOut), 64'(e.lo));
                checkVal("divZeroF", 64'(divZeroF), 64'(e.dz));
            end
        end
    end

    task automatic mtWrite(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        hiWe = 1'b1; wrData = h;
        @(negedge clk);
        hiWe = 1'b0; loWe = 1'b1; wrData = l;
        @(negedge clk);
        loWe = 1'b0;
        mHi = h; mLo = l;
    endtask

    // Issues one op, checks latency and busy duration; optionally pokes start/hiWe mid-CALC.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit midPoke);
        exp_t        e;
        int unsigned n;
        int unsigned busyCnt;
        int unsigned expLat;
        bit          gotDone;
        @(negedge clk);
        start = 1'b1; mdop = op; portA = a; portB = b;
        e = model(op, a, b, mHi, mLo);
        sbQ.push_back(e);
        mHi = e.hi; mLo = e.lo;
        expLat = (op[1] && b == 32'd0) ? 1 : 33;
        @(posedge clk);
        #1;
        start = 1'b0; portA = $urandom; portB = $urandom; mdop = 2'($urandom);
        checkVal("busy_after_start", 64'(busy), 64'd1);
        busyCnt = busy ? 1 : 0;
        n = 0;
        gotDone = 1'b0;
        while (!gotDone && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (midPoke && n == 5) begin
                start = 1'b1; mdop = 2'd3; portA = 32'd1000; portB = 32'd7;
                hiWe = 1'b1; loWe = 1'b1; wrData = 32'hDEAD_BEEF;
            end else if (midPoke && n == 6) begin
                start = 1'b0; hiWe = 1'b0; loWe = 1'b0;
            end
            if (done) gotDone = 1'b1;
            else if (busy) busyCnt++;
        end
        checkVal("latency", 64'(n), 64'(expLat));
        checkVal("busy_cycles", 64'(busyCnt), 64'(expLat));
        checkVal("busy_at_done", 64'(busy), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit sawDone;
        #12;
        checkVal("rst_busy", 64'(busy), 64'd0);
        checkVal("rst_done", 64'(done), 64'd0);
        checkVal("rst_dz", 64'(divZeroF), 64'd0);
        checkVal("rst_hilo", {hiOut, loOut}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp(2'd0, -32'sd4, 32'd45, 1'b0);
        runOp(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        runOp(2'd2, -32'sd10, 32'd3, 1'b0);
        runOp(2'd3, 32'd89, 32'd67, 1'b0);
        runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        runOp(2'd2, 32'd7, -32'sd2, 1'b0);
        runOp(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);

        mtWrite(32'h11, 32'h22);
        checkVal("mthi", 64'(hiOut), 64'h11);
        checkVal("mtlo", 64'(loOut), 64'h22);
        runOp(2'd2, 32'd50, 32'd0, 1'b0);

        // Start and hiWe/loWe poked mid-CALC must be ignored.
        runOp(2'd0, 32'd12345, -32'sd678, 1'b1);
        // Issued straight from the done cycle: back-to-back acceptance.
        runOp(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
        runOp(2'd3, 32'hFFFF_FFFF, 32'd16, 1'b0);
        for (int i = 0; i < 4; i++) begin
            runOp(2'($urandom_range(0, 3)), $urandom, $urandom_range(1, 32'hFFFF_FFFF), 1'b0);
        end

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start = 1'b1; mdop = 2'd0; portA = 32'd7; portB = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("async_rst_busy", 64'(busy), 64'd0);
        checkVal("async_rst_hilo", {hiOut, loOut}, 64'd0);
        mHi = '0; mLo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkVal("no_done_after_rst", 64'(sawDone), 64'd0);

        runOp(2'd2, -32'sd100, -32'sd7, 1'b0);
        repeat (3) @(negedge clk);
        checkVal("queue_empty", 64'(sbQ.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
